// File: rtl/sram_port0_arbiter_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM port-0 arbiter.
//   arb_state_e : arbiter FSM state (clear sequence / normal service)
//   req_id_t    : requester index (0 = host/DMA, 1 = accelerator core)
//   ARB_*       : memory geometry (depth in words, address/data/strobe widths)
package sram_arb_pkg;
  localparam int ARB_DEPTH = 480;
  localparam int ARB_AW    = 16;
  localparam int ARB_DW    = 32;
  localparam int ARB_BE    = 4;

  typedef enum logic {ST_INIT, ST_SERVE} arb_state_e;
  typedef logic req_id_t;
endpackage

// File: rtl/sram_port0_arbiter_if.sv
// sram_port0_arbiter_if: one requester's view of SRAM port 0.
//   master : requester side (drives valid/we/addr/wdata, takes ready/rvalid/rdata)
//   slave  : arbiter side
// Request: valid/ready handshake, we=0 means read. Response: rvalid pulse
// with rdata, no backpressure.
interface sram_port0_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int AW = ARB_AW
);
  logic              valid;
  logic              ready;
  logic [ARB_BE-1:0] we;
  logic [AW-1:0]     addr;
  logic [ARB_DW-1:0] wdata;
  logic              rvalid;
  logic [ARB_DW-1:0] rdata;

  modport master (output valid, we, addr, wdata, input ready, rvalid, rdata);
  modport slave  (input valid, we, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/sram_port0_arbiter_rr_arb2.sv
// rr_arb2: 2-way round-robin grant.
//   clk, rst : clock, async active-high reset
//   en       : grants allowed this cycle
//   req      : request vector, bit N = requester N
//   gnt      : one-hot grant (combinational, same cycle as req)
//   gnt_id   : index of the granted requester (valid when |gnt)
// rr_last remembers the most recent winner; on a tie the other side wins.
// It resets to 1 so requester 0 wins the first tie.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output req_id_t    gnt_id
);
  req_id_t rr_last;

  always_comb begin
    gnt = '0;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = rr_last ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  assign gnt_id = gnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_last <= 1'b1;
    else if (|gnt) rr_last <= gnt[1];
  end
endmodule

// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: shares port 0 of the 480x32b byte-banked SRAM between
// r0 (host/DMA) and r1 (accelerator core).
//   clk, rst     : clock, async active-high reset
//   r0, r1       : requester interfaces (slave modport)
//   sram_wea/addr/wdata : to SRAM port 0, combinational from state + grant
//   sram_rdata   : from SRAM port 0, valid the cycle after the address
//   init_done    : high once service starts
//   err_oob      : pulse on an accepted request with addr >= DEPTH
// Build option SRAM_ARB_INIT_CLEAR_EN: when defined, the FSM starts in
// ST_INIT and zero-fills all DEPTH words before serving requests; when
// undefined, it starts directly in ST_SERVE and memory contents are
// whatever the SRAM powered up with.
module sram_port0_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = ARB_DEPTH,
  parameter int AW    = ARB_AW
)(
  input  logic              clk,
  input  logic              rst,
  sram_port0_arbiter_if.slave r0,
  sram_port0_arbiter_if.slave r1,
  output logic [ARB_BE-1:0] sram_wea,
  output logic [AW-1:0]     sram_addr,
  output logic [ARB_DW-1:0] sram_wdata,
  input  logic [ARB_DW-1:0] sram_rdata,
  output logic              init_done,
  output logic              err_oob
);
  localparam int              CW       = $clog2(DEPTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEPTH - 1);
  localparam logic [AW-1:0]   DEPTH_A  = AW'(DEPTH);
`ifdef SRAM_ARB_INIT_CLEAR_EN
  localparam arb_state_e      RST_ST   = ST_INIT;
`else
  localparam arb_state_e      RST_ST   = ST_SERVE;
`endif

  arb_state_e    state_q, state_d;
  logic [CW-1:0] clr_cnt_q, clr_cnt_d;

  // Requests gathered into lane-indexed packed arrays.
  logic [1:0]             req_vld;
  logic [1:0][ARB_BE-1:0] req_we;
  logic [1:0][AW-1:0]     req_addr;
  logic [1:0][ARB_DW-1:0] req_wdata;

  assign req_vld   = {r1.valid, r0.valid};
  assign req_we    = {r1.we,    r0.we};
  assign req_addr  = {r1.addr,  r0.addr};
  assign req_wdata = {r1.wdata, r0.wdata};

  // Outputs are forced to their reset values while rst is high, since the
  // state-decoded outputs would otherwise show INIT/SERVE values in reset.
  logic       serve;
  logic [1:0] gnt;
  req_id_t    sel;
  logic       g_any, g_oob;

  assign serve = (state_q == ST_SERVE) && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (serve),
    .req    (req_vld),
    .gnt    (gnt),
    .gnt_id (sel)
  );

  assign g_any    = |gnt;
  assign g_oob    = g_any && (req_addr[sel] >= DEPTH_A);
  assign r0.ready = gnt[0];
  assign r1.ready = gnt[1];
  assign err_oob  = g_oob;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    sram_wea   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    init_done  = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          sram_wea  = '1;
          sram_addr = AW'(clr_cnt_q);
          if (clr_cnt_q == CNT_LAST) state_d = ST_SERVE;
          else                       clr_cnt_d = clr_cnt_q + 1'b1;
        end
        ST_SERVE: begin
          init_done = 1'b1;
          if (g_any) begin
            sram_addr  = req_addr[sel];
            sram_wdata = req_wdata[sel];
            // Out-of-bounds requests are accepted but must never write.
            sram_wea   = g_oob ? '0 : req_we[sel];
          end
        end
        default: state_d = RST_ST;
      endcase
    end
  end

  // Read return tracking: one outstanding read, answered the next cycle.
  logic                   rd_pend_q, rd_oob_q;
  req_id_t                rd_owner_q;
  logic [1:0][ARB_DW-1:0] rdata_q;
  logic [ARB_DW-1:0]      ret_data;

  assign ret_data = rd_oob_q ? '0 : sram_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_ST;
      clr_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      rd_oob_q   <= 1'b0;
      rd_owner_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_pend_q  <= g_any && (req_we[sel] == '0);
      rd_oob_q   <= g_oob;
      rd_owner_q <= sel;
      if (rd_pend_q) rdata_q[rd_owner_q] <= ret_data;
    end
  end

  // rdata shows the fresh SRAM word in the return cycle, then holds it.
  assign r0.rvalid = rd_pend_q && (rd_owner_q == 1'b0);
  assign r1.rvalid = rd_pend_q && (rd_owner_q == 1'b1);
  assign r0.rdata  = r0.rvalid ? ret_data : rdata_q[0];
  assign r1.rdata  = r1.rvalid ? ret_data : rdata_q[1];
endmodule
